// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: write FIFO feeding a back-to-back frame serialiser.
// Data width, parity mode and stop-bit count are set by parameters.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 10417,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          WR_EN,
  input  logic [DATA_BITS-1:0]          WR_DATA,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          OVERFLOW,
  output logic                          BUSY,
  output logic                          UART_TX
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLK_DIV);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
      PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter set");
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 push;
  logic                 pop;
  logic                 head_vld;
  logic [DATA_BITS-1:0] head;

  logic [2:0]           state;
  logic [TW-1:0]        timer;
  logic [2:0]           bit_idx;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic                 tick;
  logic                 last_stop;

  assign FULL  = count == (AW+1)'(FIFO_DEPTH);
  assign EMPTY = count == '0;
  assign COUNT = count;
  assign BUSY  = state != S_IDLE;
  assign head  = mem[rd_ptr];
  assign push  = WR_EN && !FULL;

  assign tick      = timer == TW'(CLK_DIV - 1);
  assign last_stop = (state == S_STOP) && tick &&
                     ((STOP_BITS == 1) || stop_cnt);
  // IDLE launches one cycle after the entry lands; STOP chains immediately
  assign pop = !EMPTY &&
               (((state == S_IDLE) && head_vld) || last_stop);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= WR_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
      head_vld <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (WR_EN && FULL) OVERFLOW <= 1'b1;
      head_vld <= !EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_q    <= 1'b0;
      UART_TX  <= 1'b1;
    end else begin
      timer <= (tick || state == S_IDLE) ? '0 : timer + 1'b1;
      unique case (state)
        S_IDLE: UART_TX <= 1'b1;
        S_START: if (tick) begin
          state   <= S_DATA;
          bit_idx <= '0;
          UART_TX <= shreg[0];
        end
        S_DATA: if (tick) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              state   <= S_PARITY;
              UART_TX <= par_q;
            end else begin
              state    <= S_STOP;
              stop_cnt <= 1'b0;
              UART_TX  <= 1'b1;
            end
          end else begin
            bit_idx <= bit_idx + 1'b1;
            shreg   <= shreg >> 1;
            UART_TX <= shreg[1];
          end
        end
        S_PARITY: if (tick) begin
          state    <= S_STOP;
          stop_cnt <= 1'b0;
          UART_TX  <= 1'b1;
        end
        S_STOP: if (tick) begin
          if (last_stop) begin
            state   <= S_IDLE;
            UART_TX <= 1'b1;
          end else begin
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          UART_TX <= 1'b1;
        end
      endcase
      // a pop always launches a fresh frame, overriding the case above
      if (pop) begin
        shreg   <= head;
        par_q   <= (^head) ^ (PARITY == 1);
        state   <= S_START;
        UART_TX <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameter sets, frame scoreboard per instance.
// Table vectors for single frames, hand sequences for FIFO corner cases.
module tb_uart_tx_fifo;

  localparam int CLK_DIV = 4;

  typedef struct {
    logic [15:0] bits;
    int          n;
  } fr_t;

  typedef struct {
    int          g;
    logic [7:0]  d;
    logic [15:0] bits;
    int          n;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst   [4];
  logic       wr_en [4];
  logic [7:0] wd    [4];
  logic       full  [4];
  logic       empty [4];
  logic [2:0] cnt   [4];
  logic       ovf   [4];
  logic       busy  [4];
  logic       tx    [4];

  int checks = 0;
  int errors = 0;

  fr_t q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .CLK(clk), .RST(rst[0]), .WR_EN(wr_en[0]), .WR_DATA(wd[0]),
    .FULL(full[0]), .EMPTY(empty[0]), .COUNT(cnt[0]),
    .OVERFLOW(ovf[0]), .BUSY(busy[0]), .UART_TX(tx[0]));

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .CLK(clk), .RST(rst[1]), .WR_EN(wr_en[1]), .WR_DATA(wd[1]),
    .FULL(full[1]), .EMPTY(empty[1]), .COUNT(cnt[1]),
    .OVERFLOW(ovf[1]), .BUSY(busy[1]), .UART_TX(tx[1]));

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
    .CLK(clk), .RST(rst[2]), .WR_EN(wr_en[2]), .WR_DATA(wd[2]),
    .FULL(full[2]), .EMPTY(empty[2]), .COUNT(cnt[2]),
    .OVERFLOW(ovf[2]), .BUSY(busy[2]), .UART_TX(tx[2]));

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(5), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .CLK(clk), .RST(rst[3]), .WR_EN(wr_en[3]), .WR_DATA(wd[3][4:0]),
    .FULL(full[3]), .EMPTY(empty[3]), .COUNT(cnt[3]),
    .OVERFLOW(ovf[3]), .BUSY(busy[3]), .UART_TX(tx[3]));

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int g, input fr_t f);
    case (g)
      0: q0.push_back(f);
      1: q1.push_back(f);
      2: q2.push_back(f);
      default: q3.push_back(f);
    endcase
  endtask

  task automatic take(input int g, output fr_t f, output bit ok);
    ok = 1'b1;
    f.bits = '0;
    f.n = 0;
    case (g)
      0: if (q0.size() > 0) f = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) f = q1.pop_front(); else ok = 1'b0;
      2: if (q2.size() > 0) f = q2.pop_front(); else ok = 1'b0;
      default: if (q3.size() > 0) f = q3.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // line monitors: each falling edge from idle consumes one expected frame
  for (genvar g = 0; g < 4; g++) begin : g_mon
    initial begin
      fr_t f;
      bit  ok;
      bit  abort;
      bit  bad;
      forever begin
        @(negedge clk);
        if (rst[g] === 1'b0 && tx[g] === 1'b0) begin
          take(g, f, ok);
          if (!ok) begin
            check($sformatf("u%0d_unexpected_frame", g), 1, 0);
            for (int k = 0; k < 200 && tx[g] === 1'b0; k++)
              @(negedge clk);
          end else begin
            abort = 1'b0;
            for (int i = 0; i < f.n && !abort; i++) begin
              bad = 1'b0;
              for (int c = 0; c < CLK_DIV; c++) begin
                if (i != 0 || c != 0) @(negedge clk);
                if (rst[g] !== 1'b0) begin
                  abort = 1'b1;
                  break;
                end
                if (tx[g] !== f.bits[i]) bad = 1'b1;
              end
              if (!abort)
                check($sformatf("u%0d_bit%0d", g, i),
                      bad ? !f.bits[i] : f.bits[i], f.bits[i]);
            end
          end
        end
      end
    end
  end

  task automatic count_busy(input int g, output int n);
    n = 0;
    while (busy[g] === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic send_check(input int g, input logic [7:0] d,
                            input logic [15:0] bits, input int n);
    fr_t f;
    int  nb;
    f.bits = bits;
    f.n = n;
    push_exp(g, f);
    @(posedge clk); #1;
    wr_en[g] = 1'b1;
    wd[g] = d;
    @(posedge clk); #1;
    wr_en[g] = 1'b0;
    @(negedge clk);
    check($sformatf("u%0d_lat0_tx", g), tx[g], 1);
    check($sformatf("u%0d_lat0_cnt", g), cnt[g], 1);
    @(negedge clk);
    check($sformatf("u%0d_lat1_tx", g), tx[g], 1);
    @(negedge clk);
    check($sformatf("u%0d_lat2_tx", g), tx[g], 0);
    count_busy(g, nb);
    check($sformatf("u%0d_busy_len", g), nb, n * CLK_DIV);
    check($sformatf("u%0d_empty_after", g), empty[g], 1);
  endtask

  vec_t vecs [8];

  initial begin
    int nb;
    fr_t f;

    vecs[0] = '{g: 0, d: 8'h55, bits: 16'h02AA, n: 10};
    vecs[1] = '{g: 1, d: 8'h07, bits: 16'h0C0E, n: 12};
    vecs[2] = '{g: 2, d: 8'h07, bits: 16'h0E0E, n: 12};
    vecs[3] = '{g: 3, d: 8'h1F, bits: 16'h007E, n: 7};
    vecs[4] = '{g: 0, d: 8'hA3, bits: 16'h0346, n: 10};
    vecs[5] = '{g: 1, d: 8'h00, bits: 16'h0E00, n: 12};
    vecs[6] = '{g: 2, d: 8'hFF, bits: 16'h0DFE, n: 12};
    vecs[7] = '{g: 3, d: 8'h0A, bits: 16'h0054, n: 7};

    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1;
      wr_en[i] = 1'b0;
      wd[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d_rst_tx", i), tx[i], 1);
      check($sformatf("u%0d_rst_busy", i), busy[i], 0);
      check($sformatf("u%0d_rst_cnt", i), cnt[i], 0);
      check($sformatf("u%0d_rst_empty", i), empty[i], 1);
      check($sformatf("u%0d_rst_full", i), full[i], 0);
      check($sformatf("u%0d_rst_ovf", i), ovf[i], 0);
    end

    for (int i = 0; i < 8; i++)
      send_check(vecs[i].g, vecs[i].d, vecs[i].bits, vecs[i].n);

    // six back-to-back writes into a 4-deep FIFO: fifth fills it, sixth drops
    @(posedge clk); #1;
    wr_en[0] = 1'b1;
    wd[0] = 8'h11;
    for (int k = 1; k <= 5; k++) begin
      f.bits = {6'b0, 1'b1, wd[0], 1'b0};
      f.n = 10;
      push_exp(0, f);
      @(posedge clk); #1;
      wd[0] = 8'h11 + 8'(k);
    end
    @(posedge clk); #1;
    wr_en[0] = 1'b0;
    @(negedge clk);
    check("ovf_full", full[0], 1);
    check("ovf_sticky", ovf[0], 1);
    check("ovf_cnt", cnt[0], 4);
    count_busy(0, nb);
    check("ovf_b2b_busy", nb, 197);
    check("ovf_drain_cnt", cnt[0], 0);
    check("ovf_drain_empty", empty[0], 1);
    check("ovf_still_set", ovf[0], 1);

    // write coinciding with the end-of-STOP pop keeps COUNT at 2
    @(posedge clk); #1;
    wr_en[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wd[0] = 8'h21 + 8'(k);
      f.bits = {6'b0, 1'b1, wd[0], 1'b0};
      f.n = 10;
      push_exp(0, f);
      @(posedge clk); #1;
    end
    wr_en[0] = 1'b0;
    repeat (39) @(posedge clk);
    @(negedge clk);
    check("sim_cnt_pre", cnt[0], 2);
    check("sim_busy_pre", busy[0], 1);
    wr_en[0] = 1'b1;
    wd[0] = 8'hC6;
    f.bits = {6'b0, 1'b1, 8'hC6, 1'b0};
    f.n = 10;
    push_exp(0, f);
    @(posedge clk); #1;
    wr_en[0] = 1'b0;
    @(negedge clk);
    check("sim_cnt_post", cnt[0], 2);
    check("sim_gap_tx", tx[0], 0);
    count_busy(0, nb);
    check("sim_b2b_busy", nb, 120);
    check("sim_drain_cnt", cnt[0], 0);

    // reset in the middle of DATA with one entry still queued
    @(posedge clk); #1;
    wr_en[0] = 1'b1;
    wd[0] = 8'h3C;
    f.bits = {6'b0, 1'b1, 8'h3C, 1'b0};
    f.n = 10;
    push_exp(0, f);
    @(posedge clk); #1;
    wd[0] = 8'h42;
    f.bits = {6'b0, 1'b1, 8'h42, 1'b0};
    push_exp(0, f);
    @(posedge clk); #1;
    wr_en[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("rst_pre_busy", busy[0], 1);
    check("rst_pre_cnt", cnt[0], 1);
    rst[0] = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", tx[0], 1);
    check("rst_mid_busy", busy[0], 0);
    check("rst_mid_cnt", cnt[0], 0);
    check("rst_mid_ovf", ovf[0], 0);
    check("rst_mid_empty", empty[0], 1);
    send_check(0, 8'h9E, {6'b0, 1'b1, 8'h9E, 1'b0}, 10);

    repeat (4) @(negedge clk);
    check("q0_left", q0.size(), 0);
    check("q1_left", q1.size(), 0);
    check("q2_left", q2.size(), 0);
    check("q3_left", q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised buffered UART transmitter for the game's serial debug/score link. A small write FIFO absorbs bursts of bytes from game logic. A serialiser drains the FIFO and sends frames back-to-back, with configurable data width, parity and stop bits. It supersedes the single-byte, fixed 8N1 transmitter.

Parameters:
CLK_DIV, 10417, clock cycles per bit period (100 MHz / 9600 baud); minimum 2.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.
FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.

Ports:
CLK  in  1  system clock.
RST  in  1  synchronous, active-high reset.
WR_EN  in  1  push WR_DATA into the FIFO.
WR_DATA  in  DATA_BITS  byte to transmit.
FULL  out  1  FIFO holds FIFO_DEPTH entries.
EMPTY  out  1  FIFO holds 0 entries.
COUNT  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
OVERFLOW  out  1  sticky; set when a write is dropped because the FIFO is full.
BUSY  out  1  serialiser is mid-frame.
UART_TX  out  1  serial line, idle high.

Behaviour:
- Reset (RST high at a CLK edge) sets UART_TX=1, BUSY=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0. All FIFO pointers and the bit timer clear.
- Reset mid-frame returns the line high at that edge. The truncated frame is not retransmitted.
- FIFO write: accepted when WR_EN=1 and FULL=0 at the edge.
- Write while FULL=1: dropped and sets OVERFLOW. This applies even if a pop happens in the same cycle. OVERFLOW is cleared only by RST.
- Simultaneous accepted write and pop: COUNT unchanged.
- FULL, EMPTY and COUNT are registered-state derived and valid every cycle.
- Serialiser states: IDLE, START, DATA, PARITY, STOP.
- IDLE: UART_TX=1, BUSY=0. If EMPTY=0, pop the head entry into the shift register and go to START.
- START: drives 0 for CLK_DIV cycles.
- DATA: sends DATA_BITS bits LSB first, CLK_DIV cycles each.
- PARITY: entered only when PARITY!=0, for CLK_DIV cycles.
  - Even mode: the bit is the XOR of the data bits.
  - Odd mode: the bit is the inverted XOR.
- STOP: drives 1 for STOP_BITS*CLK_DIV cycles.
- End of STOP: if EMPTY=0, pop in that same cycle and go straight to START, so there is zero idle gap between frames. Otherwise go to IDLE.
- BUSY is 1 in START, DATA, PARITY and STOP.
- Frame length is exactly (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV cycles.
- Latency: a write into an empty FIFO while in IDLE at edge N makes UART_TX low after edge N+2. The entry becomes visible at N+1 and START is entered at N+2.
- WR_DATA bits above DATA_BITS do not exist; WR_DATA width follows the parameter.
- Bit timer counts 0..CLK_DIV-1 and wraps at each bit boundary. There is no cumulative drift.
- COUNT decrements on the pop edge, not at end of frame.
- Illegal parameters are a compile-time error, raised by a generate-time check.

Test Plan:
- CLK_DIV=4, 8N1: write 0x55 once → UART_TX low 2 edges later; line pattern 0,1,0,1,0,1,0,1,0,1 with each bit held exactly 4 cycles; BUSY high for 40 cycles, then 0.
- CLK_DIV=4, PARITY=1, STOP_BITS=2: write 0x07 → parity bit 0 (three ones); frame is 12 bits = 48 cycles. Repeat with PARITY=2 → parity bit 1.
- DATA_BITS=5: write 0x1F → only 5 data bits sent; frame is 7 bits = 28 cycles.
- FIFO_DEPTH=4: write 6 bytes in consecutive cycles.
  - Expect: bytes 1–5 accepted (first pops immediately), byte 6 dropped; FULL=1 and OVERFLOW=1 after the attempt.
  - Expect: 5 frames sent back-to-back with no idle cycle between stop and start, then COUNT=0 and EMPTY=1.
- Simultaneous write and pop at the end-of-STOP edge with COUNT=2 → COUNT stays 2 and the next frame starts with zero gap.
- Assert RST mid-DATA → UART_TX=1, BUSY=0, COUNT=0 and OVERFLOW=0 after that edge; a following write transmits normally.
